// File: rtl/wr_burst_fifo.sv
// Write-data burst buffer: single-clock FIFO that requests the controller once a full burst is held.
// Optional per-byte write mask storage is enabled with `define WR_BURST_FIFO_MASK_EN.
module wr_burst_fifo #(
  parameter int DATA_WIDTH  = 128,
  parameter int WRITE_BURST = 8,
  parameter int DEPTH       = 64,
  parameter int ADDR_WIDTH  = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   wr_fifo_in,
  input  logic                    wr_fifo_vd,
`ifdef WR_BURST_FIFO_MASK_EN
  input  logic [DATA_WIDTH/8-1:0] wr_mask_in,
  output logic [DATA_WIDTH/8-1:0] wr_mask_out,
`endif
  input  logic                    burst_ack,
  output logic                    burst_req,
  output logic [DATA_WIDTH-1:0]   wr_data_out,
  output logic                    wr_data_vd,
  output logic                    burst_last,
  output logic                    full,
  output logic                    almost_full,
  output logic                    empty,
  output logic                    almost_empty,
  output logic                    overflow
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int BW = (WRITE_BURST > 1) ? $clog2(WRITE_BURST) : 1;
  localparam logic [CW-1:0]         DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0]         WB_C      = CW'(WRITE_BURST);
  localparam logic [CW-1:0]         AF_C      = CW'(DEPTH - WRITE_BURST);
  localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
  localparam logic [BW-1:0]         BEAT_ONE  = BW'(1);
  localparam logic [BW-1:0]         LAST_BEAT = BW'(WRITE_BURST - 1);

  typedef enum logic [1:0] {IDLE, REQ, SEND} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic                    overflow_q, overflow_d;
  logic                    vd_q, vd_d, last_q, last_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic                    push, pop;
`ifdef WR_BURST_FIFO_MASK_EN
  logic [DATA_WIDTH/8-1:0] mask_mem_q [DEPTH];
  logic [DATA_WIDTH/8-1:0] mask_q, mask_d;
`endif

  // Flags decode the registered count, so a push into a full FIFO is dropped even on a pop cycle.
  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= AF_C);
  assign empty        = (count_q == '0);
  assign almost_empty = (count_q < WB_C);
  assign overflow     = overflow_q;
  assign burst_req    = (state_q == REQ);
  assign wr_data_out  = dout_q;
  assign wr_data_vd   = vd_q;
  assign burst_last   = last_q;
`ifdef WR_BURST_FIFO_MASK_EN
  assign wr_mask_out  = mask_q;
`endif

  always_comb begin
    push       = wr_fifo_vd & ~full;
    pop        = (state_q == SEND);
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    beat_d     = beat_q;
    overflow_d = overflow_q | (wr_fifo_vd & full);
    vd_d       = pop;
    last_d     = 1'b0;
    dout_d     = dout_q;
`ifdef WR_BURST_FIFO_MASK_EN
    mask_d     = mask_q;
`endif
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      dout_d   = mem_q[rd_ptr_q];
`ifdef WR_BURST_FIFO_MASK_EN
      mask_d   = mask_mem_q[rd_ptr_q];
`endif
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // REQ is only entered with a full burst held, so SEND never underflows.
    case (state_q)
      IDLE: if (count_q >= WB_C) state_d = REQ;
      REQ:  if (burst_ack) state_d = SEND;
      SEND: begin
        last_d = (beat_q == LAST_BEAT);
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = IDLE;
        end else begin
          beat_d = beat_q + BEAT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      beat_q     <= '0;
      overflow_q <= 1'b0;
      vd_q       <= 1'b0;
      last_q     <= 1'b0;
      dout_q     <= '0;
`ifdef WR_BURST_FIFO_MASK_EN
      mask_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      beat_q     <= beat_d;
      overflow_q <= overflow_d;
      vd_q       <= vd_d;
      last_q     <= last_d;
      dout_q     <= dout_d;
`ifdef WR_BURST_FIFO_MASK_EN
      mask_q     <= mask_d;
`endif
    end
  end

  // Storage is not reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= wr_fifo_in;
`ifdef WR_BURST_FIFO_MASK_EN
      mask_mem_q[wr_ptr_q] <= wr_mask_in;
`endif
    end
  end

endmodule

// File: tb/tb_wr_burst_fifo.sv
// Randomized bench for wr_burst_fifo checked every cycle against a queue-based reference model.
module tb_wr_burst_fifo;
  localparam int DW = 128, WB = 8, DEPTH = 64, AW = 6, MW = DW / 8;

  logic          clk = 1'b0;
  logic          reset, wr_fifo_vd, burst_ack;
  logic [DW-1:0] wr_fifo_in, wr_data_out;
  logic          burst_req, wr_data_vd, burst_last, full, almost_full, empty, almost_empty, overflow;
`ifdef WR_BURST_FIFO_MASK_EN
  logic [MW-1:0] wr_mask_in, wr_mask_out;
`endif

  always #5 clk = ~clk;

  wr_burst_fifo #(.DATA_WIDTH(DW), .WRITE_BURST(WB), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .wr_fifo_in(wr_fifo_in), .wr_fifo_vd(wr_fifo_vd),
`ifdef WR_BURST_FIFO_MASK_EN
    .wr_mask_in(wr_mask_in), .wr_mask_out(wr_mask_out),
`endif
    .burst_ack(burst_ack), .burst_req(burst_req), .wr_data_out(wr_data_out),
    .wr_data_vd(wr_data_vd), .burst_last(burst_last), .full(full), .almost_full(almost_full),
    .empty(empty), .almost_empty(almost_empty), .overflow(overflow)
  );

  typedef struct { logic [DW-1:0] d; logic [MW-1:0] m; } ent_t;
  ent_t          q[$];
  bit            m_req;
  int            m_left;
  logic          m_vd, m_last, m_ovf;
  logic [DW-1:0] m_dout;
  logic [MW-1:0] m_mask;
  int            n_vec, n_err;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: the FIFO is a queue; a burst is "m_left words still to send".
  task automatic model_edge(input logic vd, input logic [DW-1:0] din, input logic [MW-1:0] mk,
                            input logic ack, input logic rst);
    int   n;
    bit   was_req, was_send;
    ent_t e;
    if (rst) begin
      q.delete(); m_req = 0; m_left = 0; m_vd = 0; m_last = 0; m_ovf = 0;
      m_dout = '0; m_mask = '0;
      return;
    end
    n = q.size(); was_req = m_req; was_send = (m_left > 0);
    if (was_send) begin
      e = q.pop_front(); m_dout = e.d; m_mask = e.m;
      m_vd = 1; m_last = (m_left == 1); m_left--;
    end else begin
      m_vd = 0; m_last = 0;
    end
    if (vd) begin
      if (n == DEPTH) m_ovf = 1;
      else begin e.d = din; e.m = mk; q.push_back(e); end
    end
    if (was_req) begin
      if (ack) begin m_req = 0; m_left = WB; end
    end else if (!was_send && n >= WB) m_req = 1;
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("burst_req",    DW'(burst_req),    DW'(m_req));
    chk("wr_data_vd",   DW'(wr_data_vd),   DW'(m_vd));
    chk("burst_last",   DW'(burst_last),   DW'(m_last));
    chk("full",         DW'(full),         DW'(n == DEPTH));
    chk("almost_full",  DW'(almost_full),  DW'(n >= DEPTH - WB));
    chk("empty",        DW'(empty),        DW'(n == 0));
    chk("almost_empty", DW'(almost_empty), DW'(n < WB));
    chk("overflow",     DW'(overflow),     DW'(m_ovf));
    chk("wr_data_out",  wr_data_out,       m_dout);
`ifdef WR_BURST_FIFO_MASK_EN
    chk("wr_mask_out",  DW'(wr_mask_out),  DW'(m_mask));
`endif
  endtask

  task automatic step(input logic vd, input logic [DW-1:0] din, input logic ack, input logic rst);
    logic [MW-1:0] mk;
    mk = din[MW-1:0] ^ din[DW-1:DW-MW] ^ MW'(16'h5a5a);
    wr_fifo_vd = vd; wr_fifo_in = din; burst_ack = ack; reset = rst;
`ifdef WR_BURST_FIFO_MASK_EN
    wr_mask_in = mk;
`endif
    @(posedge clk);
    model_edge(vd, din, mk, ack, rst);
    #1;
    check_all();
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0;
    m_req = 0; m_left = 0; m_vd = 0; m_last = 0; m_ovf = 0; m_dout = '0; m_mask = '0;
    step(0, '0, 0, 1); step(0, '0, 0, 1);
    repeat (10) step(0, '0, 0, 0);
    chk("reset_empty", DW'(empty), DW'(1'b1));
    chk("reset_req",   DW'(burst_req), DW'(1'b0));

    // single burst 1..8, ack on first request cycle
    for (int i = 1; i <= 8; i++) step(1, DW'(i), 0, 0);
    repeat (20) step(0, '0, m_req, 0);
    chk("drain_empty", DW'(empty), DW'(1'b1));

    // 7 words hold no request; the 8th raises it
    for (int i = 1; i <= 7; i++) step(1, rnd(), 0, 0);
    repeat (20) step(0, '0, 0, 0);
    chk("seven_no_req", DW'(burst_req), DW'(1'b0));
    step(1, rnd(), 0, 0);
    step(0, '0, 0, 0);
    chk("eighth_req", DW'(burst_req), DW'(1'b1));
    repeat (20) step(0, '0, m_req, 0);

    // fill past full without ack
    for (int i = 1; i <= 65; i++) step(1, DW'(i), 0, 0);
    chk("fill_full", DW'(full), DW'(1'b1));
    chk("fill_ovf",  DW'(overflow), DW'(1'b1));
    step(0, '0, 1, 0);
    repeat (8) step(0, '0, 0, 0);
    chk("after_pop_full",  DW'(full), DW'(1'b0));
    chk("after_pop_afull", DW'(almost_full), DW'(1'b1));
    repeat (120) step(0, '0, m_req, 0);
    step(0, '0, 0, 1);

    // continuous pushes with ack held high
    repeat (40) step(1, rnd(), 1, 0);
    repeat (40) step(0, '0, 1, 0);

    // reset during beat 4
    for (int i = 0; i < 8; i++) step(1, rnd(), 0, 0);
    for (int i = 0; i < 5 && !m_req; i++) step(0, '0, 0, 0);
    step(0, '0, 1, 0);
    repeat (4) step(0, '0, 0, 0);
    step(0, '0, 0, 1);
    chk("rst_vd",    DW'(wr_data_vd), DW'(1'b0));
    chk("rst_empty", DW'(empty), DW'(1'b1));
    repeat (10) step(0, '0, 1, 0);
    for (int i = 0; i < 8; i++) step(1, rnd(), 0, 0);
    step(0, '0, 0, 0);
    chk("rst_refill_req", DW'(burst_req), DW'(1'b1));
    repeat (20) step(0, '0, m_req, 0);

    // random traffic with occasional reset
    for (int i = 0; i < 2500; i++)
      step($urandom_range(0, 99) < 60, rnd(), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 599) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
